// File: rtl/enc_pkg.sv
// Shared types and constants for the rotary-encoder readout path.
package enc_pkg;

    localparam int CNT_W        = 16;
    localparam int BYTE_W       = CNT_W / 2;
    localparam int SETTLE_DEF   = 4;
    localparam int LOCK_CYC_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCK,
        S_LOCK_GAP,
        S_CS_HI,
        S_CS_LO,
        S_PRESENT
    } state_t;

endpackage

// File: rtl/enc_period_timer.sv
// Free-running 0..PERIOD-1 counter; tick marks the wrap. PERIOD=0 disables it.
module enc_period_timer #(
    parameter int PERIOD = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    if (PERIOD == 0) begin : g_off
        logic unused_in;
        assign unused_in = clk ^ reset;
        assign tick      = 1'b0;
    end else begin : g_on
        localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
        logic [W-1:0] cnt;

        assign tick = (cnt == W'(PERIOD - 1));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/enc_read_ctrl.sv
// Encoder readout sequencer: lock, two-byte read over cs, valid/ready present.
// Optional ENC_DELTA_EN adds a signed delta output against the last accepted sample.
module enc_read_ctrl
    import enc_pkg::*;
#(
    parameter int SETTLE   = SETTLE_DEF,
    parameter int LOCK_CYC = LOCK_CYC_DEF,
    parameter int PERIOD   = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] enc_data,
    output logic              enc_lock,
    output logic              enc_cs,
    output logic [CNT_W-1:0]  sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              overrun,
    input  logic              overrun_clr
`ifdef ENC_DELTA_EN
    ,
    output logic signed [CNT_W-1:0] delta
`endif
);

    localparam int CMAX = (SETTLE > LOCK_CYC) ? SETTLE : LOCK_CYC;
    localparam int CTW  = $clog2(CMAX + 1);

    state_t            state, state_d;
    logic [CTW-1:0]    cnt, cnt_d;
    logic [BYTE_W-1:0] hi, hi_d;
    logic [CNT_W-1:0]  sample_d;
    logic              pend, pend_d;
    logic              valid_d, ovr_d, lock_d, cs_d;
    logic              tick, trig, ovr_set;
`ifdef ENC_DELTA_EN
    logic [CNT_W-1:0]  prev, prev_d, delta_d;
`endif

    enc_period_timer #(.PERIOD(PERIOD)) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign trig = start | tick;
    assign busy = (state != S_IDLE) && (state != S_PRESENT);

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        hi_d     = hi;
        sample_d = sample;
        valid_d  = sample_valid;
        pend_d   = pend;
        ovr_set  = 1'b0;
`ifdef ENC_DELTA_EN
        prev_d   = prev;
        delta_d  = delta;
`endif
        // Outside IDLE one trigger may wait; a second one is lost.
        if (state != S_IDLE && trig) begin
            if (pend) ovr_set = 1'b1;
            else      pend_d  = 1'b1;
        end
        unique case (state)
            S_IDLE: begin
                if (trig || pend) begin
                    state_d = S_LOCK;
                    cnt_d   = '0;
                    pend_d  = pend & trig;
                end
            end
            S_LOCK: begin
                if (cnt == CTW'(LOCK_CYC - 1)) begin
                    state_d = S_LOCK_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CTW'(1);
                end
            end
            S_LOCK_GAP: begin
                state_d = S_CS_HI;
                cnt_d   = '0;
            end
            S_CS_HI: begin
                if (cnt == CTW'(SETTLE - 1)) begin
                    hi_d    = enc_data;
                    state_d = S_CS_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CTW'(1);
                end
            end
            S_CS_LO: begin
                if (cnt == CTW'(SETTLE - 1)) begin
                    sample_d = {hi, enc_data};
                    valid_d  = 1'b1;
                    state_d  = S_PRESENT;
                    cnt_d    = '0;
`ifdef ENC_DELTA_EN
                    delta_d  = {hi, enc_data} - prev;
`endif
                end else begin
                    cnt_d = cnt + CTW'(1);
                end
            end
            S_PRESENT: begin
                if (sample_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
`ifdef ENC_DELTA_EN
                    prev_d  = sample;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        ovr_d  = ovr_set | (overrun & ~overrun_clr);
        // Strobes are registered from the next state so they never glitch.
        lock_d = (state_d == S_LOCK);
        cs_d   = (state_d == S_CS_HI);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            hi           <= '0;
            pend         <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            enc_lock     <= 1'b0;
            enc_cs       <= 1'b0;
`ifdef ENC_DELTA_EN
            prev         <= '0;
            delta        <= '0;
`endif
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            hi           <= hi_d;
            pend         <= pend_d;
            sample       <= sample_d;
            sample_valid <= valid_d;
            overrun      <= ovr_d;
            enc_lock     <= lock_d;
            enc_cs       <= cs_d;
`ifdef ENC_DELTA_EN
            prev         <= prev_d;
            delta        <= delta_d;
`endif
        end
    end

endmodule

// File: tb/tb_enc_read_ctrl.sv
// Bench for enc_read_ctrl: two instances (timer off / PERIOD=20) against a
// phase-timeline reference model, plus hand-computed scenario checks.
module tb_enc_read_ctrl;

    localparam int L   = 2;
    localparam int S   = 4;
    localparam int LAT = L + 1 + 2 * S + 1;
    localparam int P0  = 0;
    localparam int P1  = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] enc_count = 16'h0000;

    logic [7:0]  data [2];
    logic        lock [2];
    logic        cs [2];
    logic        busy [2];
    logic        vld [2];
    logic        ovr [2];
    logic [15:0] smp [2];
    logic [15:0] dlt [2];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    enc_read_ctrl #(.SETTLE(S), .LOCK_CYC(L), .PERIOD(P0)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .enc_data     (data[0]),
        .enc_lock     (lock[0]),
        .enc_cs       (cs[0]),
        .sample       (smp[0]),
        .sample_valid (vld[0]),
        .sample_ready (ready),
        .busy         (busy[0]),
        .overrun      (ovr[0]),
        .overrun_clr  (clr)
`ifdef ENC_DELTA_EN
        ,
        .delta        (dlt[0])
`endif
    );

    enc_read_ctrl #(.SETTLE(S), .LOCK_CYC(L), .PERIOD(P1)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .enc_data     (data[1]),
        .enc_lock     (lock[1]),
        .enc_cs       (cs[1]),
        .sample       (smp[1]),
        .sample_valid (vld[1]),
        .sample_ready (ready),
        .busy         (busy[1]),
        .overrun      (ovr[1]),
        .overrun_clr  (clr)
`ifdef ENC_DELTA_EN
        ,
        .delta        (dlt[1])
`endif
    );

`ifndef ENC_DELTA_EN
    assign dlt[0] = 16'h0000;
    assign dlt[1] = 16'h0000;
`endif

    // Encoder: latch count on lock, 2-flop cs sync, registered byte mux.
    logic [15:0] locked [2] = '{16'h0, 16'h0};
    logic        s1 [2] = '{1'b0, 1'b0};
    logic        s2 [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (lock[i]) locked[i] <= enc_count;
            s1[i]   <= cs[i];
            s2[i]   <= s1[i];
            data[i] <= s2[i] ? locked[i][15:8] : locked[i][7:0];
        end
    end

    // Model: a sequence is a timeline of phases counted from its trigger edge.
    typedef struct {
        bit          act;
        int          ph;
        bit          pend;
        bit          ovr;
        bit          vld;
        logic [15:0] smp;
        logic [7:0]  hi;
        logic [15:0] prev;
        logic [15:0] dlt;
        int          tcnt;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t mreset();
        mdl_t s;
        s.act  = 0;
        s.ph   = 0;
        s.pend = 0;
        s.ovr  = 0;
        s.vld  = 0;
        s.smp  = 16'h0;
        s.hi   = 8'h0;
        s.prev = 16'h0;
        s.dlt  = 16'h0;
        s.tcnt = 0;
        return s;
    endfunction

    function automatic mdl_t mstep(mdl_t s, int per, bit st, bit rdy,
                                   bit cl, logic [7:0] d);
        bit tk;
        bit trg;
        bit set;
        tk  = (per != 0) && (s.tcnt == per - 1);
        if (per != 0) s.tcnt = tk ? 0 : s.tcnt + 1;
        trg = st | tk;
        set = 0;
        if (!s.act) begin
            if (trg || s.pend) begin
                s.act  = 1;
                s.ph   = 1;
                s.pend = s.pend && trg;
            end
        end else begin
            if (trg) begin
                if (s.pend) set = 1;
                else        s.pend = 1;
            end
            if (s.ph < LAT) begin
                if (s.ph == L + 1 + S) s.hi = d;
                if (s.ph == L + 1 + 2 * S) begin
                    s.smp = {s.hi, d};
                    s.vld = 1;
                    s.dlt = s.smp - s.prev;
                end
                s.ph++;
            end else if (rdy) begin
                s.vld  = 0;
                s.act  = 0;
                s.prev = s.smp;
            end
        end
        s.ovr = set | (s.ovr & !cl);
        return s;
    endfunction

    always @(negedge clk) begin
        logic [20:0] e;
        logic [20:0] a;
        cyc++;
        if (!reset) begin
            m[0] = mreset();
            m[1] = mreset();
        end
        for (int i = 0; i < 2; i++) begin
            e = {m[i].act && m[i].ph >= 1 && m[i].ph <= L,
                 m[i].act && m[i].ph >= L + 2 && m[i].ph <= L + 1 + S,
                 m[i].act && m[i].ph < LAT,
                 m[i].vld, m[i].ovr, m[i].smp};
            a = {lock[i], cs[i], busy[i], vld[i], ovr[i], smp[i]};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL model_cmp cyc=%0d inst=%0d {lock,cs,busy,vld,ovr,sample} got=%h expected=%h",
                         cyc, i, a, e);
            end
`ifdef ENC_DELTA_EN
            tests++;
            if (dlt[i] !== m[i].dlt) begin
                fails++;
                $display("FAIL model_delta cyc=%0d inst=%0d got=%h expected=%h",
                         cyc, i, dlt[i], m[i].dlt);
            end
`endif
        end
        if (reset) begin
            m[0] = mstep(m[0], P0, start, ready, clr, data[0]);
            m[1] = mstep(m[1], P1, start, ready, clr, data[1]);
        end
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(string n);
        int k;
        k = 0;
        while (vld[0] !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        chk(n, 32'(vld[0]), 32'd1);
    endtask

    task automatic accept();
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    initial begin
        logic [15:0] held;
        logic        stable;
        int          last;
        logic        bad;
        logic        pl;

        #1 reset = 1'b0;
        step(3);
        chk("rst_lock", 32'(lock[0]), 0);
        chk("rst_cs", 32'(cs[0]), 0);
        chk("rst_valid", 32'(vld[0]), 0);
        chk("rst_sample", 32'(smp[0]), 0);
        chk("rst_overrun", 32'(ovr[1]), 0);
        reset = 1'b1;
        step(2);

        // Basic read, cycle numbers counted from the start cycle.
        enc_count = 16'h12A5;
        pulse_start();
        chk("basic_lock_c1", 32'(lock[0]), 1);
        step();
        chk("basic_lock_c2", 32'(lock[0]), 1);
        step();
        chk("basic_lock_c3", 32'(lock[0]), 0);
        step();
        chk("basic_cs_c4", 32'(cs[0]), 1);
        step(6);
        chk("basic_cs_c10", 32'(cs[0]), 0);
        step();
        chk("basic_valid_c11", 32'(vld[0]), 0);
        step();
        chk("basic_valid_c12", 32'(vld[0]), 1);
        chk("basic_sample_c12", 32'(smp[0]), 32'h12A5);
        step(2);
        accept();
        chk("basic_valid_c15", 32'(vld[0]), 0);
        chk("basic_sample_hold", 32'(smp[0]), 32'h12A5);

        // Backpressure with one pending and one dropped trigger.
        enc_count = 16'h3C5A;
        pulse_start();
        wait_valid("bp_valid");
        held   = smp[0];
        stable = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (k == 30) chk("bp_no_overrun_yet", 32'(ovr[0]), 0);
            start = (k == 10 || k == 30);
            step();
            if (smp[0] !== held || vld[0] !== 1'b1) stable = 1'b0;
        end
        start = 1'b0;
        chk("bp_stable", 32'(stable), 1);
        chk("bp_sample", 32'(held), 32'h3C5A);
        chk("bp_overrun", 32'(ovr[0]), 1);
        accept();
        chk("bp_idle_gap_lock", 32'(lock[0]), 0);
        chk("bp_idle_gap_busy", 32'(busy[0]), 0);
        step();
        chk("bp_pending_lock", 32'(lock[0]), 1);
        wait_valid("bp_pending_valid");
        accept();

        // Clear, then clear coincident with a new overrun.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_overrun", 32'(ovr[0]), 0);
        pulse_start();
        step(2);
        pulse_start();
        step();
        start = 1'b1;
        clr   = 1'b1;
        step();
        start = 1'b0;
        clr   = 1'b0;
        chk("clr_set_wins", 32'(ovr[0]), 1);
        wait_valid("clr_valid1");
        accept();
        wait_valid("clr_valid2");
        accept();
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Periodic reads on the PERIOD=20 instance.
        ready = 1'b1;
        step(40);
        last = -1;
        bad  = 1'b0;
        pl   = lock[1];
        for (int k = 0; k < 120; k++) begin
            step();
            if (lock[1] && !pl) begin
                if (last >= 0 && k - last != P1) bad = 1'b1;
                last = k;
            end
            if (busy[1] && vld[1]) bad = 1'b1;
            pl = lock[1];
        end
        chk("periodic_spacing", 32'(bad), 0);
        chk("periodic_seen", 32'(last >= 0), 1);
        chk("periodic_overrun", 32'(ovr[1]), 0);

        // start coincident with a timer tick while idle.
        for (int k = 0; k < 100; k++) begin
            if (!m[1].act && !m[1].pend && m[1].tcnt == P1 - 1) break;
            step();
        end
        pulse_start();
        chk("coinc_lock", 32'(lock[1]), 1);
        step(LAT);
        chk("coinc_idle", 32'(busy[1]), 0);
        step();
        chk("coinc_single_lock", 32'(lock[1]), 0);
        chk("coinc_single_busy", 32'(busy[1]), 0);
        chk("coinc_overrun", 32'(ovr[1]), 0);
        ready = 1'b0;

        // Asynchronous reset during CS_HI.
        enc_count = 16'h0BEE;
        pulse_start();
        step(5);
        chk("mid_cs_before", 32'(cs[0]), 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(cs[0]), 0);
        chk("mid_rst_lock", 32'(lock[0]), 0);
        chk("mid_rst_valid", 32'(vld[0]), 0);
        chk("mid_rst_sample", 32'(smp[0]), 0);
        step(2);
        reset = 1'b1;
        step();
        pulse_start();
        wait_valid("mid_after_valid");
        chk("mid_after_sample", 32'(smp[0]), 32'h0BEE);
        accept();

`ifdef ENC_DELTA_EN
        enc_count = 16'hFFFE;
        pulse_start();
        wait_valid("delta_v1");
        accept();
        enc_count = 16'h0002;
        pulse_start();
        wait_valid("delta_v2");
        chk("delta_wrap", 32'(dlt[0]), 32'h0004);
        accept();
        enc_count = 16'h0000;
        pulse_start();
        wait_valid("delta_v3");
        chk("delta_neg", 32'(dlt[0]), 32'hFFFE);
        accept();
`endif

        // Random traffic checked cycle by cycle against the model.
        for (int k = 0; k < 2000; k++) begin
            start = ($urandom_range(0, 9) == 0);
            ready = $urandom_range(0, 1) == 1;
            clr   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) enc_count = 16'($urandom);
            step();
        end
        start = 1'b0;
        clr   = 1'b0;
        ready = 1'b1;
        step(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
